// File: rtl/memory_request_arbiter.sv
// Shares one sram-like memory port between instruction fetch and data access,
// tracking in-order outstanding transactions so each response reaches its originator.
module memory_request_arbiter #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int OUTSTANDING   = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      inst_request,
   input  logic [ADDRESS_WIDTH-1:0]  inst_address,
   output logic                      inst_address_ok,
   output logic                      inst_data_ok,
   output logic [DATA_WIDTH-1:0]     inst_read_data,
   input  logic                      data_request,
   input  logic                      data_write,
   input  logic [1:0]                data_size,
   input  logic [DATA_WIDTH/8-1:0]   data_strobe,
   input  logic [ADDRESS_WIDTH-1:0]  data_address,
   input  logic [DATA_WIDTH-1:0]     data_write_data,
   output logic                      data_address_ok,
   output logic                      data_data_ok,
   output logic [DATA_WIDTH-1:0]     data_read_data,
   input  logic                      flush,
   output logic                      memory_request,
   output logic                      memory_write,
   output logic [1:0]                memory_size,
   output logic [DATA_WIDTH/8-1:0]   memory_strobe,
   output logic [ADDRESS_WIDTH-1:0]  memory_address,
   output logic [DATA_WIDTH-1:0]     memory_write_data,
   input  logic                      memory_address_ok,
   input  logic                      memory_data_ok,
   input  logic [DATA_WIDTH-1:0]     memory_read_data,
   output logic                      protocol_error
);

   localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int CW = $clog2(OUTSTANDING + 1);
   localparam int TW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CW-1:0] COUNT_MAX  = CW'(OUTSTANDING);
   localparam logic [PW-1:0] PTR_LAST   = PW'(OUTSTANDING - 1);
   localparam logic [TW-1:0] STARVE_MAX = TW'(STARVE_LIMIT);

   typedef enum logic {SRC_INST = 1'b0, SRC_DATA = 1'b1} source_t;

   source_t         src_q  [OUTSTANDING];
   source_t         src_d  [OUTSTANDING];
   logic            disc_q [OUTSTANDING];
   logic            disc_d [OUTSTANDING];
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [TW-1:0]   starve_q, starve_d;
   logic            perr_q, perr_d;

   logic grant_inst, grant_data, can_issue, mem_req, accept;
   logic head_valid, pop, stray;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Every handshake is gated by reset so nothing leaks out while it is held low.
   always_comb begin
      grant_inst = inst_request & ~flush & (~data_request | (starve_q == STARVE_MAX));
      grant_data = data_request & ~grant_inst;
      can_issue  = (count_q < COUNT_MAX);
      mem_req    = reset & can_issue & (grant_inst | grant_data);
      accept     = mem_req & memory_address_ok;
      head_valid = (count_q != '0);
      pop        = reset & memory_data_ok & head_valid;
      stray      = reset & memory_data_ok & ~head_valid;
   end

   assign memory_request    = mem_req;
   assign memory_write      = grant_data ? data_write      : 1'b0;
   assign memory_size       = grant_data ? data_size       : 2'd2;
   assign memory_strobe     = grant_data ? data_strobe     : '0;
   assign memory_address    = grant_data ? data_address    : inst_address;
   assign memory_write_data = grant_data ? data_write_data : '0;
   assign inst_address_ok   = accept & grant_inst;
   assign data_address_ok   = accept & grant_data;
   assign inst_data_ok      = pop & (src_q[head_q] == SRC_INST) & ~disc_q[head_q] & ~flush;
   assign data_data_ok      = pop & (src_q[head_q] == SRC_DATA);
   assign inst_read_data    = memory_read_data;
   assign data_read_data    = memory_read_data;
   assign protocol_error    = perr_q;

   // Flush marks inst entries first; a push in the same cycle can only be data.
   always_comb begin
      src_d   = src_q;
      disc_d  = disc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         for (int i = 0; i < OUTSTANDING; i++) begin
            if (src_q[i] == SRC_INST) disc_d[i] = 1'b1;
         end
      end
      if (accept) begin
         src_d[tail_q]  = grant_data ? SRC_DATA : SRC_INST;
         disc_d[tail_q] = 1'b0;
         tail_d         = next_ptr(tail_q);
      end
      if (pop) head_d = next_ptr(head_q);
      case ({accept, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      starve_d = starve_q;
      if (!inst_request || inst_address_ok) starve_d = '0;
      else if (data_address_ok && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
      perr_d = perr_q | stray;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < OUTSTANDING; i++) begin
            src_q[i]  <= SRC_INST;
            disc_q[i] <= 1'b0;
         end
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         starve_q <= '0;
         perr_q   <= 1'b0;
      end else begin
         src_q    <= src_d;
         disc_q   <= disc_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         perr_q   <= perr_d;
      end
   end

endmodule
